// File: rtl/dual_lock_requester_if.sv
// Handshake bundle between a transaction source, the two lock arbiters and
// the dual-lock requester.
interface dual_lock_requester_if;
    logic       START;
    logic       NEED_A;
    logic       NEED_B;
    logic       GNTA;
    logic       GNTB;
    logic       REQA;
    logic       REQB;
    logic       busy;
    logic       done;
    logic       abort;
    logic [7:0] retry_cnt;

    // master: the requester itself; slave: source plus arbiters
    modport master (
        input  START, NEED_A, NEED_B, GNTA, GNTB,
        output REQA, REQB, busy, done, abort, retry_cnt
    );

    modport slave (
        output START, NEED_A, NEED_B, GNTA, GNTB,
        input  REQA, REQB, busy, done, abort, retry_cnt
    );
endinterface

// File: rtl/dual_lock_requester.sv
// Two-resource lock initiator: acquires A then B, holds, releases; a per-wait
// watchdog aborts and retries after an LFSR-derived backoff.
//
// state   | meaning
// IDLE    | no transaction, waiting for START
// WAIT_A  | REQA high, waiting for GNTA under watchdog
// WAIT_B  | REQB high (REQA kept if needed), waiting for GNTB under watchdog
// BACKOFF | all requests dropped after timeout, waiting before retry
// HOLD    | all needed resources granted, held for HOLD cycles
module dual_lock_requester #(
    parameter int          TIMEOUT      = 17,
    parameter int          HOLD         = 4,
    parameter int          BACKOFF_BITS = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                  CLK,
    input  logic                  RST,
    dual_lock_requester_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_A  = 3'd1;
    localparam logic [2:0] WAIT_B  = 3'd2;
    localparam logic [2:0] BACKOFF = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    localparam int          CW        = 16;
    localparam logic [CW-1:0] WD_LOAD   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic          need_a;
    logic          need_b;
    logic          reqa_q;
    logic          reqb_q;
    logic          busy_q;
    logic          done_q;
    logic          abort_q;
    logic [7:0]    retry_q;

    // Galois form of x^16 + x^14 + x^13 + x^11, shifting right
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            lfsr    <= SEED;
            need_a  <= 1'b0;
            need_b  <= 1'b0;
            reqa_q  <= 1'b0;
            reqb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            retry_q <= 8'd0;
        end else begin
            lfsr    <= lfsr_next;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        if (bus.NEED_A || bus.NEED_B) begin
                            need_a  <= bus.NEED_A;
                            need_b  <= bus.NEED_B;
                            busy_q  <= 1'b1;
                            retry_q <= 8'd0;
                            cnt     <= WD_LOAD;
                            if (bus.NEED_A) begin
                                state  <= WAIT_A;
                                reqa_q <= 1'b1;
                            end else begin
                                state  <= WAIT_B;
                                reqb_q <= 1'b1;
                            end
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                WAIT_A: begin
                    // grant is checked first so a grant on the timeout cycle wins
                    if (bus.GNTA) begin
                        if (need_b) begin
                            state  <= WAIT_B;
                            reqb_q <= 1'b1;
                            cnt    <= WD_LOAD;
                        end else begin
                            state <= ST_HOLD;
                            cnt   <= HOLD_LOAD;
                        end
                    end else if (cnt == '0) begin
                        state   <= BACKOFF;
                        reqa_q  <= 1'b0;
                        reqb_q  <= 1'b0;
                        abort_q <= 1'b1;
                        cnt     <= CW'(lfsr[BACKOFF_BITS-1:0]);
                        if (retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_B: begin
                    if (bus.GNTB) begin
                        state <= ST_HOLD;
                        cnt   <= HOLD_LOAD;
                    end else if (cnt == '0) begin
                        state   <= BACKOFF;
                        reqa_q  <= 1'b0;
                        reqb_q  <= 1'b0;
                        abort_q <= 1'b1;
                        cnt     <= CW'(lfsr[BACKOFF_BITS-1:0]);
                        if (retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BACKOFF: begin
                    if (cnt == '0) begin
                        cnt <= WD_LOAD;
                        if (need_a) begin
                            state  <= WAIT_A;
                            reqa_q <= 1'b1;
                        end else begin
                            state  <= WAIT_B;
                            reqb_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        reqa_q <= 1'b0;
                        reqb_q <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    reqa_q <= 1'b0;
                    reqb_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.REQA      = reqa_q;
    assign bus.REQB      = reqb_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.abort     = abort_q;
    assign bus.retry_cnt = retry_q;
endmodule

// File: tb/tb_dual_lock_requester.sv
// Directed bench for dual_lock_requester with TIMEOUT=5, HOLD=4.
module tb_dual_lock_requester;
    logic CLK;
    logic RST;
    int   vectors;
    int   miscompares;
    int   n;

    dual_lock_requester_if bus ();

    dual_lock_requester #(
        .TIMEOUT     (5),
        .HOLD        (4),
        .BACKOFF_BITS(2),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ticks until REQA is high, returning the number of edges taken (bounded)
    task automatic wait_reqa(output int cnt_edges);
        cnt_edges = 0;
        do begin
            tick(1);
            cnt_edges++;
        end while (bus.REQA !== 1'b1 && cnt_edges < 8);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        RST = 1'b1;
        bus.START = 1'b0; bus.NEED_A = 1'b0; bus.NEED_B = 1'b0;
        bus.GNTA = 1'b0;  bus.GNTB = 1'b0;
        tick(2);
        chk("rst_reqa", 32'(bus.REQA), 32'd0);
        chk("rst_reqb", 32'(bus.REQB), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_abort", 32'(bus.abort), 32'd0);
        chk("rst_retry", 32'(bus.retry_cnt), 32'd0);
        RST = 1'b0;
        tick(1);

        // normal two-resource flow
        bus.START = 1'b1; bus.NEED_A = 1'b1; bus.NEED_B = 1'b1;
        tick(1);
        bus.START = 1'b0;
        chk("n_reqa_rise", 32'(bus.REQA), 32'd1);
        chk("n_reqb_low", 32'(bus.REQB), 32'd0);
        chk("n_busy", 32'(bus.busy), 32'd1);
        tick(1);
        bus.GNTA = 1'b1;
        tick(1);
        chk("n_reqb_rise", 32'(bus.REQB), 32'd1);
        chk("n_reqa_keep", 32'(bus.REQA), 32'd1);
        tick(2);
        bus.GNTB = 1'b1;
        tick(1);
        tick(3);
        chk("n_hold_reqa", 32'(bus.REQA), 32'd1);
        chk("n_hold_reqb", 32'(bus.REQB), 32'd1);
        chk("n_hold_nodone", 32'(bus.done), 32'd0);
        tick(1);
        chk("n_done", 32'(bus.done), 32'd1);
        chk("n_rel_reqa", 32'(bus.REQA), 32'd0);
        chk("n_rel_reqb", 32'(bus.REQB), 32'd0);
        chk("n_rel_busy", 32'(bus.busy), 32'd0);
        chk("n_retry", 32'(bus.retry_cnt), 32'd0);
        bus.GNTA = 1'b0; bus.GNTB = 1'b0;
        tick(1);
        chk("n_done_pulse", 32'(bus.done), 32'd0);

        // timeout on A
        bus.START = 1'b1; bus.NEED_A = 1'b1; bus.NEED_B = 1'b0;
        tick(1);
        bus.START = 1'b0;
        chk("t_reqa_rise", 32'(bus.REQA), 32'd1);
        tick(4);
        chk("t_pre_reqa", 32'(bus.REQA), 32'd1);
        chk("t_pre_abort", 32'(bus.abort), 32'd0);
        tick(1);
        chk("t_abort", 32'(bus.abort), 32'd1);
        chk("t_reqa_fall", 32'(bus.REQA), 32'd0);
        chk("t_retry1", 32'(bus.retry_cnt), 32'd1);
        chk("t_busy", 32'(bus.busy), 32'd1);
        wait_reqa(n);
        chk("t_backoff_range", 32'(n >= 1 && n <= 4), 32'd1);
        chk("t_back_reqa", 32'(bus.REQA), 32'd1);
        chk("t_abort_once", 32'(bus.abort), 32'd0);
        tick(4);
        chk("t2_pre_abort", 32'(bus.abort), 32'd0);
        tick(1);
        chk("t2_abort", 32'(bus.abort), 32'd1);
        chk("t_retry2", 32'(bus.retry_cnt), 32'd2);
        wait_reqa(n);
        chk("t2_backoff_range", 32'(n >= 1 && n <= 4), 32'd1);
        bus.GNTA = 1'b1;
        tick(1);
        bus.GNTA = 1'b0;
        chk("t_hold_reqa", 32'(bus.REQA), 32'd1);
        chk("t_hold_reqb", 32'(bus.REQB), 32'd0);
        tick(4);
        chk("t_done", 32'(bus.done), 32'd1);
        chk("t_done_noabort", 32'(bus.abort), 32'd0);
        chk("t_retry_kept", 32'(bus.retry_cnt), 32'd2);
        tick(1);

        // partial grant deadlock, then START ignored during HOLD
        bus.START = 1'b1; bus.NEED_A = 1'b1; bus.NEED_B = 1'b1;
        tick(1);
        bus.START = 1'b0;
        chk("d_retry_clr", 32'(bus.retry_cnt), 32'd0);
        bus.GNTA = 1'b1;
        tick(1);
        chk("d_reqb_rise", 32'(bus.REQB), 32'd1);
        tick(4);
        chk("d_pre_both", 32'({bus.REQA, bus.REQB}), 32'd3);
        tick(1);
        chk("d_both_fall", 32'({bus.REQA, bus.REQB}), 32'd0);
        chk("d_abort", 32'(bus.abort), 32'd1);
        chk("d_retry", 32'(bus.retry_cnt), 32'd1);
        wait_reqa(n);
        chk("d_backoff_range", 32'(n >= 1 && n <= 4), 32'd1);
        chk("d_retry_wait_a", 32'({bus.REQA, bus.REQB}), 32'd2);
        tick(1);
        chk("d_again_b", 32'({bus.REQA, bus.REQB}), 32'd3);
        bus.GNTB = 1'b1;
        tick(1);
        bus.START = 1'b1; bus.NEED_A = 1'b0; bus.NEED_B = 1'b0;
        bus.GNTA = 1'b0;  bus.GNTB = 1'b0;
        tick(1);
        bus.START = 1'b0;
        chk("h_grant_drop_ign", 32'({bus.REQA, bus.REQB}), 32'd3);
        chk("h_busy", 32'(bus.busy), 32'd1);
        tick(3);
        chk("h_done", 32'(bus.done), 32'd1);
        tick(1);
        chk("h_single_done", 32'(bus.done), 32'd0);
        chk("h_idle_busy", 32'(bus.busy), 32'd0);
        chk("h_idle_reqa", 32'(bus.REQA), 32'd0);

        // grant arrives exactly on the timeout cycle
        bus.START = 1'b1; bus.NEED_A = 1'b1; bus.NEED_B = 1'b1;
        tick(1);
        bus.START = 1'b0;
        tick(4);
        bus.GNTA = 1'b1;
        tick(1);
        chk("b_no_abort", 32'(bus.abort), 32'd0);
        chk("b_wait_b", 32'({bus.REQA, bus.REQB}), 32'd3);
        bus.GNTB = 1'b1;
        tick(5);
        chk("b_done", 32'(bus.done), 32'd1);
        chk("b_retry", 32'(bus.retry_cnt), 32'd0);
        bus.GNTA = 1'b0; bus.GNTB = 1'b0;
        tick(1);

        // START with no needs
        bus.START = 1'b1; bus.NEED_A = 1'b0; bus.NEED_B = 1'b0;
        tick(1);
        bus.START = 1'b0;
        chk("z_done", 32'(bus.done), 32'd1);
        chk("z_noreq", 32'({bus.REQA, bus.REQB}), 32'd0);
        chk("z_busy", 32'(bus.busy), 32'd0);
        tick(1);
        chk("z_done_pulse", 32'(bus.done), 32'd0);

        // reset during WAIT_B, then fresh START
        bus.START = 1'b1; bus.NEED_A = 1'b0; bus.NEED_B = 1'b1;
        tick(1);
        bus.START = 1'b0;
        chk("r_wait_b", 32'({bus.REQA, bus.REQB}), 32'd1);
        tick(1);
        RST = 1'b1;
        tick(1);
        chk("r_outputs", 32'({bus.REQA, bus.REQB, bus.busy, bus.done, bus.abort}), 32'd0);
        chk("r_retry", 32'(bus.retry_cnt), 32'd0);
        tick(1);
        RST = 1'b0;
        bus.START = 1'b1; bus.NEED_A = 1'b1; bus.NEED_B = 1'b0;
        tick(1);
        bus.START = 1'b0;
        chk("r_fresh_reqa", 32'(bus.REQA), 32'd1);
        chk("r_fresh_busy", 32'(bus.busy), 32'd1);
        bus.GNTA = 1'b1;
        tick(5);
        chk("r_fresh_done", 32'(bus.done), 32'd1);
        bus.GNTA = 1'b0;
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dual_lock_requester.md
Name: dual_lock_requester

Overview:
- Synthesizable, clocked initiator for the two-resource request/grant lock protocol.
- Acquires resource A, then resource B (either or both per transaction), holds them, then releases.
- A per-wait watchdog drops all requests on timeout and retries after a pseudo-random backoff, breaking cross-requester deadlock.
- Sits between a transaction source and two request/grant arbiters.

Parameters:
TIMEOUT, 17, cycles waited for one grant before abort (min 2)
HOLD, 4, cycles all needed resources are held once granted (min 1)
BACKOFF_BITS, 2, backoff length = 1 + LFSR[BACKOFF_BITS-1:0] cycles
LFSR_SEED, 16'hACE1, reset value of backoff LFSR (0 is forced to 1)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
START  in  1  transaction request pulse, accepted only when busy=0
NEED_A  in  1  resource A required, sampled with START
NEED_B  in  1  resource B required, sampled with START
GNTA  in  1  grant for resource A
GNTB  in  1  grant for resource B
REQA  out  1  request for resource A, registered
REQB  out  1  request for resource B, registered
busy  out  1  transaction in progress
done  out  1  one-cycle pulse, transaction completed and resources released
abort  out  1  one-cycle pulse, watchdog expired, all requests dropped
retry_cnt  out  8  aborts in current transaction, saturates at 255

Behaviour:
- Reset values: REQA=REQB=busy=done=abort=0; retry_cnt=0; state IDLE; LFSR=LFSR_SEED (1 if seed is 0). RST has priority over all other inputs in every state.
- Outputs are registered: a decision at edge k is visible from edge k.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every cycle outside reset.
- IDLE:
  - START with NEED_A|NEED_B: latch the needs, set busy=1, clear retry_cnt. Go to WAIT_A if need_a, else WAIT_B.
  - START with neither need: done pulses, state stays IDLE.
- WAIT_A:
  - REQA=1, watchdog counts from 0 (cleared on entry).
  - GNTA=1: go to WAIT_B if need_b, else HOLD. REQA stays high.
  - Watchdog reaches TIMEOUT-1 with GNTA=0: go to BACKOFF.
- WAIT_B:
  - REQB=1; REQA stays high if need_a. Watchdog is cleared on entry.
  - GNTB=1: go to HOLD.
  - Timeout: go to BACKOFF.
- Grant and timeout in the same cycle: grant wins, no abort.
- Timeout → BACKOFF:
  - REQA and REQB both drop in the same edge, including a resource already granted.
  - abort pulses once.
  - retry_cnt increments, saturating at 255.
  - Backoff length is latched from the LFSR at entry.
- BACKOFF: requests low, busy=1. After 1..2^BACKOFF_BITS cycles, re-enter WAIT_A (if need_a) else WAIT_B.
- HOLD:
  - Needed REQs stay high for exactly HOLD cycles, then all REQs drop, done pulses, busy=0, go to IDLE.
  - Grant deassertion during HOLD is ignored.
- Completion timing: done, busy=0 and REQ low occur on the same edge. The next START is accepted the following cycle.
- START while busy=1 is ignored; latched needs are unchanged.
- done and abort are never asserted together.

Test Plan:
- Reset: hold RST 2 cycles mid-activity → REQA=REQB=busy=done=abort=0, retry_cnt=0 on the edge after RST rises.
- Normal two-resource flow: START, NEED_A=1, NEED_B=1; GNTA 2 cycles after REQA rise; GNTB 3 cycles after REQB rise → REQA then REQB high. After GNTB, HOLD=4 cycles, then both drop with a single done pulse; retry_cnt=0.
- Timeout on A: TIMEOUT=5, GNTA held 0 → abort pulses with REQA falling 5 cycles after REQA rose. REQA re-rises 1..4 cycles later; retry_cnt=1, then 2 after the second timeout.
- Partial grant deadlock: NEED_A=NEED_B=1, GNTA=1, GNTB=0 → on timeout REQA and REQB fall on the same edge. Abort pulses and the retry starts again at WAIT_A.
- Boundary: GNTA rises exactly on the timeout cycle → no abort, proceeds to WAIT_B. START with NEED_A=NEED_B=0 → done pulse, no REQ.
- Busy handling: START pulsed during HOLD → ignored, single done. RST asserted during WAIT_B → all outputs 0 next edge, IDLE; a fresh START is accepted after RST is released.
